// File: rtl/fifo_reader_if.sv
// Bundle between fifo_reader, the FIFO read port and the downstream stream.
//
// Handshake (m_valid/m_ready): a word transfers on every rising edge where
// m_valid and m_ready are both 1. Once m_valid is raised it stays raised,
// and m_data stays unchanged, until that transfer happens. m_valid never
// depends on m_ready. m_ready may change at any time.
interface fifo_reader_if #(
   parameter int FIFO_WIDTH = 16
);
   logic                  fifo_empty;
   logic                  fifo_underflow;
   logic [FIFO_WIDTH-1:0] fifo_data_out;
   logic                  fifo_rd_en;
   logic [FIFO_WIDTH-1:0] m_data;
   logic                  m_valid;
   logic                  m_ready;

   // Reader side: pulls from the FIFO and drives the output stream.
   modport master (
      input  fifo_empty, fifo_underflow, fifo_data_out, m_ready,
      output fifo_rd_en, m_data, m_valid
   );

   // Environment side: the FIFO read port plus the stream consumer.
   modport slave (
      output fifo_empty, fifo_underflow, fifo_data_out, m_ready,
      input  fifo_rd_en, m_data, m_valid
   );
endinterface

// File: rtl/fifo_reader.sv
// Consumer-side controller for the synchronous FIFO. Reads are issued only
// when the 2-entry skid buffer is sure to have room for the returned word.
// Each word returned one cycle later is captured and presented on a
// valid/ready stream.
module fifo_reader #(
   parameter int FIFO_WIDTH = 16,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   fifo_reader_if.master        bus,
   output logic [CNT_WIDTH-1:0] words_read,
   output logic                 underflow_err,
   output logic                 busy,
   output logic [1:0]           dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_FLUSH  = 2'd2
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [1:0]            occ;
   logic                  infl;
   logic [FIFO_WIDTH-1:0] buf_head;
   logic [FIFO_WIDTH-1:0] buf_tail;
   logic                  pop;
   logic                  push;
   logic                  drop;
   logic [2:0]            pending;
   logic                  credit_ok;
   logic                  rd_issue;

   // A read is safe when buffered words plus the one in flight, minus the
   // word leaving this cycle, leave room for one more.
   assign pending   = {1'b0, occ} + {2'b00, infl};
   assign credit_ok = pending < (3'd2 + {2'b00, pop});

   assign bus.m_valid = (occ != 2'd0);
   assign bus.m_data  = buf_head;
   assign pop         = (occ != 2'd0) & bus.m_ready;
   assign push        = infl & ~bus.fifo_underflow;
   assign drop        = infl & bus.fifo_underflow;

   // The read request is forced low while reset is held.
   assign bus.fifo_rd_en = rd_issue & rst_n;

   assign busy      = (state != ST_IDLE);
   assign dbg_state = state;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and read-issue decision.
   always_comb begin
      state_nxt = state;
      rd_issue  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (enable) begin
               state_nxt = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            rd_issue = enable & ~bus.fifo_empty & credit_ok;
            if (!enable) begin
               state_nxt = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (enable) begin
               state_nxt = ST_ACTIVE;
            end else if ((occ == 2'd0) && !infl) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // In-flight flag: the FIFO returns data one cycle after a read.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         infl <= 1'b0;
      end else begin
         infl <= bus.fifo_rd_en;
      end
   end

   // Skid buffer: head is the presented word, tail holds the second one.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         occ      <= 2'd0;
         buf_head <= '0;
         buf_tail <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (occ == 2'd0) begin
                  buf_head <= bus.fifo_data_out;
               end else begin
                  buf_tail <= bus.fifo_data_out;
               end
               occ <= occ + 2'd1;
            end
            2'b01: begin
               buf_head <= buf_tail;
               occ      <= occ - 2'd1;
            end
            2'b11: begin
               // Occupancy is unchanged; the new word goes behind any survivor.
               if (occ == 2'd1) begin
                  buf_head <= bus.fifo_data_out;
               end else begin
                  buf_head <= buf_tail;
                  buf_tail <= bus.fifo_data_out;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Delivered-word counter (wraps) and sticky underflow flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         words_read    <= '0;
         underflow_err <= 1'b0;
      end else begin
         if (pop) begin
            words_read <= words_read + CNT_WIDTH'(1);
         end
         if (drop) begin
            underflow_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: a queue-based FIFO drives the read port. A
// behavioural model tracks the words owed downstream and is compared with
// the outputs every cycle. Directed scenarios add literal expectations.
module tb_fifo_reader;
   localparam int W  = 16;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable;
   logic [CW-1:0] words_read;
   logic          underflow_err;
   logic          busy;
   logic [1:0]    dbg_state;

   fifo_reader_if #(.FIFO_WIDTH(W)) bus();

   fifo_reader #(.FIFO_WIDTH(W), .CNT_WIDTH(CW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .bus           (bus),
      .words_read    (words_read),
      .underflow_err (underflow_err),
      .busy          (busy),
      .dbg_state     (dbg_state)
   );

   // Clock and bookkeeping.
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   // FIFO contents and the response it will present after the next edge.
   logic [W-1:0] fifo_q[$];
   logic [W-1:0] nxt_data  = '0;
   logic         nxt_uf    = 1'b0;
   logic         inject_uf = 1'b0;

   // Model: words owed downstream, in order, plus the in-flight word.
   logic [W-1:0]  exp_q[$];
   logic          en_prev   = 1'b0;
   logic          busy_m    = 1'b0;
   logic          infl_m    = 1'b0;
   logic          infl_drop = 1'b0;
   logic [W-1:0]  infl_data = '0;
   logic          err_m     = 1'b0;
   logic [CW-1:0] cnt_m     = '0;

   // Observations from the DUT used by the directed scenarios.
   int rd_count  = 0;
   int pop_count = 0;
   int first_rd  = -1;
   int first_vld = -1;

   logic exp_rd;
   logic exp_pop;
   logic exp_valid;
   logic act_rd;
   int   occ_m;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // Driver: advance n cycles, presenting the FIFO response after each edge.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         bus.fifo_data_out  = nxt_data;
         bus.fifo_underflow = nxt_uf;
         bus.fifo_empty     = (fifo_q.size() == 0);
      end
   endtask

   task automatic push_word(input logic [W-1:0] w);
      fifo_q.push_back(w);
      bus.fifo_empty = 1'b0;
   endtask

   // Scoreboard: compare against the model, then advance model and FIFO.
   always @(negedge clk) begin
      cycle++;
      act_rd = bus.fifo_rd_en;
      if (!rst_n) begin
         check("rd_en_in_reset", act_rd, 1'b0);
         exp_q.delete();
         en_prev = 1'b0;
         busy_m  = 1'b0;
         infl_m  = 1'b0;
         err_m   = 1'b0;
         cnt_m   = '0;
      end else begin
         occ_m     = exp_q.size();
         exp_valid = (occ_m > 0);
         exp_pop   = exp_valid && bus.m_ready;
         exp_rd    = en_prev && enable && !bus.fifo_empty &&
                     ((occ_m + int'(infl_m) - int'(exp_pop)) < 2);
         check("fifo_rd_en", act_rd, exp_rd);
         check("m_valid", bus.m_valid, exp_valid);
         if (exp_valid) check("m_data", bus.m_data, exp_q[0]);
         check("words_read", words_read, cnt_m);
         check("underflow_err", underflow_err, err_m);
         check("busy", busy, busy_m);

         if (act_rd) begin
            rd_count++;
            if (first_rd < 0) first_rd = cycle;
         end
         if (bus.m_valid === 1'b1 && first_vld < 0) first_vld = cycle;
         if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) pop_count++;

         busy_m  = enable || en_prev || (busy_m && (occ_m > 0 || infl_m));
         en_prev = enable;
         if (exp_pop) begin
            void'(exp_q.pop_front());
            cnt_m++;
         end
         if (infl_m) begin
            if (infl_drop) err_m = 1'b1;
            else exp_q.push_back(infl_data);
         end
         check("occupancy_le_2", (exp_q.size() <= 2), 1'b1);
         infl_m = act_rd;
      end

      if (act_rd === 1'b1) begin
         if (fifo_q.size() > 0) begin
            infl_data = fifo_q.pop_front();
            infl_drop = inject_uf;
            inject_uf = 1'b0;
         end else begin
            infl_data = W'($urandom);
            infl_drop = 1'b1;
         end
         nxt_data = infl_data;
         nxt_uf   = infl_drop;
      end else begin
         nxt_data = W'($urandom);
         nxt_uf   = 1'b0;
      end
   end

   // Directed scenarios, a randomized phase, then the summary.
   initial begin
      rst_n              = 1'b0;
      enable             = 1'b1;
      bus.m_ready        = 1'b1;
      bus.fifo_empty     = 1'b1;
      bus.fifo_underflow = 1'b0;
      bus.fifo_data_out  = '0;

      // Reset with the FIFO holding 3 words.
      for (int i = 0; i < 3; i++) push_word(W'(16'hA000 + i));
      step(2);
      check("reset_rd_en", bus.fifo_rd_en, 1'b0);
      check("reset_m_valid", bus.m_valid, 1'b0);
      check("reset_m_data", bus.m_data, 16'h0000);
      check("reset_words_read", words_read, 8'd0);
      check("reset_busy", busy, 1'b0);
      check("reset_underflow_err", underflow_err, 1'b0);
      fifo_q.delete();
      bus.fifo_empty = 1'b1;
      enable = 1'b0;
      rst_n  = 1'b1;
      step(2);

      // Streaming 0x0001..0x0008.
      first_rd  = -1;
      first_vld = -1;
      pop_count = 0;
      for (int i = 1; i <= 8; i++) push_word(W'(i));
      enable = 1'b1;
      step(16);
      check("stream_latency", 32'(first_vld - first_rd), 32'd2);
      check("stream_pops", 32'(pop_count), 32'd8);
      check("stream_words_read", words_read, 8'd8);
      check("stream_rd_en_empty", bus.fifo_rd_en, 1'b0);

      // Backpressure with 5 words.
      bus.m_ready = 1'b0;
      rd_count = 0;
      for (int i = 1; i <= 5; i++) push_word(W'(16'h0100 + i));
      step(10);
      check("bp_reads", 32'(rd_count), 32'd2);
      check("bp_m_valid", bus.m_valid, 1'b1);
      check("bp_m_data", bus.m_data, 16'h0101);
      bus.m_ready = 1'b1;
      pop_count = 0;
      step(12);
      check("bp_drain_pops", 32'(pop_count), 32'd5);
      check("bp_words_read", words_read, 8'd13);

      // Flush: disable one cycle after the second read, one word buffered.
      bus.m_ready = 1'b0;
      rd_count = 0;
      for (int i = 1; i <= 4; i++) push_word(W'(16'h0200 + i));
      for (int k = 0; k < 20 && rd_count < 2; k++) step(1);
      check("flush_setup_reads", 32'(rd_count), 32'd2);
      enable      = 1'b0;
      bus.m_ready = 1'b1;
      rd_count  = 0;
      pop_count = 0;
      step(8);
      check("flush_no_reads", 32'(rd_count), 32'd0);
      check("flush_pops", 32'(pop_count), 32'd2);
      check("flush_busy", busy, 1'b0);
      check("flush_words_read", words_read, 8'd15);
      fifo_q.delete();
      bus.fifo_empty = 1'b1;

      // Forced underflow on a single read.
      enable    = 1'b1;
      inject_uf = 1'b1;
      push_word(16'h0301);
      step(6);
      check("uf_err_set", underflow_err, 1'b1);
      check("uf_words_read", words_read, 8'd15);
      check("uf_m_valid", bus.m_valid, 1'b0);
      push_word(16'h0302);
      push_word(16'h0303);
      step(6);
      check("uf_err_held", underflow_err, 1'b1);
      check("uf_after_words_read", words_read, 8'd17);

      // Randomized traffic with toggling enable, backpressure, resets.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0 && fifo_q.size() < 8) push_word(W'($urandom));
         enable      = ($urandom_range(0, 9) != 0);
         bus.m_ready = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 40) == 0) inject_uf = 1'b1;
         rst_n = ($urandom_range(0, 150) != 0);
         step(1);
      end

      // Reset mid-operation with the FIFO holding 3 words.
      inject_uf = 1'b0;
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) push_word(W'(16'hB000 + i));
      step(1);
      check("midreset_m_valid", bus.m_valid, 1'b0);
      check("midreset_words_read", words_read, 8'd0);
      check("midreset_busy", busy, 1'b0);
      check("midreset_underflow_err", underflow_err, 1'b0);
      fifo_q.delete();
      bus.fifo_empty = 1'b1;
      rst_n = 1'b1;
      step(2);

      // Counter wrap: 256 words through.
      enable      = 1'b1;
      bus.m_ready = 1'b1;
      pop_count   = 0;
      for (int i = 0; i < 256; i++) push_word(W'($urandom));
      for (int k = 0; k < 400 && pop_count < 256; k++) step(1);
      check("wrap_pops", 32'(pop_count), 32'd256);
      check("wrap_words_read", words_read, 8'd0);
      enable = 1'b0;
      step(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_reader.md
# fifo_reader

Consumer-side controller for the team's synchronous FIFO. It watches the FIFO status flags and issues `rd_en` only when a read is safe. It captures `data_out` after the FIFO's one-cycle read latency and presents each word on a valid/ready output stream through a 2-entry skid buffer. It pairs with the FIFO's write-side driver and closes the loop so the FIFO can be exercised from both ends.

## Interface
- `FIFO_WIDTH`, 16: data word width; matches FIFO `data_in`/`data_out`.
- `CNT_WIDTH`, 8: width of the delivered-word counter.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `enable`  in  1  1 = fetch from FIFO; 0 = stop fetching and flush buffered words.
- `fifo_empty`  in  1  FIFO empty flag, valid in the current cycle.
- `fifo_underflow`  in  1  FIFO underflow flag; asserted the cycle after a read of an empty FIFO.
- `fifo_data_out`  in  FIFO_WIDTH  FIFO read data; valid the cycle after `fifo_rd_en`.
- `fifo_rd_en`  out  1  FIFO read request; combinational.
- `m_data`  out  FIFO_WIDTH  output word (buffer head), registered.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream accept.
- `words_read`  out  CNT_WIDTH  count of words accepted downstream; wraps.
- `underflow_err`  out  1  sticky; set by an underflow seen on a cycle following `fifo_rd_en`.
- `busy`  out  1  1 in ACTIVE or FLUSH state.

## Operation
- **Reset values:** `fifo_rd_en` 0 (gated by `rst_n` while reset is low), `m_data` 0, `m_valid` 0, `words_read` 0, `underflow_err` 0, `busy` 0. State is IDLE, buffer occupancy `occ` is 0, in-flight flag `infl` is 0.
- **States:**
  - IDLE -> ACTIVE when `enable`=1.
  - ACTIVE -> FLUSH when `enable`=0.
  - FLUSH -> ACTIVE when `enable`=1.
  - FLUSH -> IDLE when `occ`=0 and `infl`=0.
- **Read issue:** `fifo_rd_en` = (state==ACTIVE) & `enable` & !`fifo_empty` & (`occ` + `infl` - pop < 2).
  - pop = `m_valid` & `m_ready`.
  - No combinational path from `m_ready` to `fifo_rd_en` other than through pop.
- **In-flight tracking:** `infl` <= `fifo_rd_en`.
- **Capture:** when `infl`=1 and `fifo_underflow`=0, write `fifo_data_out` into the buffer tail.
  - When `infl`=1 and `fifo_underflow`=1, drop the word and set `underflow_err`.
- **Buffer:** 2-entry, in order. `m_valid` = (`occ`>0) and `m_data` = head entry. Simultaneous push and pop leaves `occ` unchanged and keeps order.
- **Counting:** `words_read` increments by 1 on each pop, modulo 2^CNT_WIDTH (255 -> 0).
- **Sticky error:** `underflow_err` clears only on reset.
- **Overflow:** the credit rule guarantees no push ever occurs with `occ`=2. An attempt to do so is a design error and a bench assertion.

## Timing
- **Read-to-output latency:** `fifo_rd_en` in cycle N -> data captured at the end of N+1 -> `m_valid`=1 with that word in N+2.
- **Throughput:** with `m_ready` held 1 and the FIFO non-empty, one read per cycle and one word per cycle sustained.
- **Backpressure:** with `m_ready`=0, at most 2 words are buffered and `fifo_rd_en` stays 0 while `occ`+`infl`=2. `m_data`/`m_valid` are held stable until accepted.
- **Empty boundary:** `fifo_empty`=1 blocks issue in that cycle. A read issued on the last FIFO word is legal; the following cycle sees `fifo_empty`=1 and issues nothing.
- **Disable mid-burst:** `enable` 1->0 stops new reads in that same cycle. An in-flight word is still captured, and buffered words drain normally in FLUSH.
- **Reset mid-operation:** buffered and in-flight words are discarded and all outputs return to reset values on the next edge. The FIFO's own reset is driven externally.

## Test plan
- **Reset:** `rst_n`=0 for 1 cycle with FIFO holding 3 words -> `fifo_rd_en`=0, `m_valid`=0, `words_read`=0, `busy`=0.
- **Streaming:** FIFO preloaded 0x0001..0x0008, `enable`=1, `m_ready`=1 -> first `m_valid` 2 cycles after first `fifo_rd_en`; 8 consecutive words in order; `words_read`=8; `fifo_rd_en` low once `fifo_empty`=1.
- **Backpressure:** FIFO holds 5 words, `m_ready`=0 for 10 cycles -> exactly 2 reads issued, `m_data`=first word stable. `m_ready`=1 then drains the remaining 5 in order with no loss or duplication.
- **Flush:** `enable` dropped one cycle after a read with 1 word buffered -> no further `fifo_rd_en`, 2 words delivered, `busy`=0 after the second pop.
- **Forced underflow:** inject `fifo_underflow`=1 on the cycle after a read -> word dropped, `underflow_err`=1 and held until reset, `words_read` unchanged.
- **Counter wrap:** 256 words through with `CNT_WIDTH`=8 -> `words_read` returns to 0.
